serial_word_collector: RTL and testbench

//   Receive end of the bit-serial multiplier datapath: samples an LSB-first serial result stream
//   (one bit per clock) and assembles it into a parallel W-bit word presented on a valid/ready port.

---
 rtl/serial_word_collector.sv | 120 ++++++++++++
 tb/tb_serial_word_collector.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_word_collector.sv
// Collects an LSB-first serial stream into a W-bit word offered on a valid/ready port.
// Optional build macro DESER_PARITY_EN adds o_parity, the XOR of all collected bits.
module serial_word_collector #(
    parameter int W    = 256,
    parameter int SKIP = 0
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic         s_bit,
    output logic [W-1:0] o_word,
    output logic         o_valid,
    input  logic         o_ready,
    output logic         busy
`ifdef DESER_PARITY_EN
    ,
    output logic         o_parity
`endif
);

    localparam int MAXWS = (W > SKIP) ? W : SKIP;
    localparam int CW    = $clog2(MAXWS) + 1;
    localparam logic [CW-1:0] W_LAST    = CW'(W - 1);
    localparam logic [CW-1:0] SKIP_LAST = CW'((SKIP > 0) ? (SKIP - 1) : 0);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SKIP,
        ST_COLLECT,
        ST_HOLD
    } state_t;

    state_t          state;
    state_t          next_state;
    logic [CW-1:0]   bit_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    next_state = (SKIP > 0) ? ST_SKIP : ST_COLLECT;
                end
            end
            ST_SKIP: begin
                if (bit_cnt == SKIP_LAST) begin
                    next_state = ST_COLLECT;
                end
            end
            ST_COLLECT: begin
                if (bit_cnt == W_LAST) begin
                    next_state = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (o_ready) begin
                    next_state = ST_IDLE;
                end
            end
            default: next_state = ST_IDLE;
        endcase
    end

    always_comb begin
        busy    = (state != ST_IDLE);
        o_valid = (state == ST_HOLD);
    end

    // Counter restarts at every state change so SKIP and COLLECT each count from zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bit_cnt <= '0;
        end else if (next_state != state) begin
            bit_cnt <= '0;
        end else if (state == ST_SKIP || state == ST_COLLECT) begin
            bit_cnt <= bit_cnt + 1'b1;
        end
    end

    generate
        if (W == 1) begin : g_word_single
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    o_word <= '0;
                end else if (state == ST_COLLECT) begin
                    o_word <= s_bit;
                end
            end
        end else begin : g_word_shift
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    o_word <= '0;
                end else if (state == ST_COLLECT) begin
                    o_word <= {s_bit, o_word[W-1:1]};
                end
            end
        end
    endgenerate

`ifdef DESER_PARITY_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            o_parity <= 1'b0;
        end else if (state != ST_COLLECT && next_state == ST_COLLECT) begin
            o_parity <= 1'b0;
        end else if (state == ST_COLLECT) begin
            o_parity <= o_parity ^ s_bit;
        end
    end
`endif

endmodule

// File: tb/tb_serial_word_collector.sv
// Directed bench for serial_word_collector: three instances (W=8/SKIP=0, W=8/SKIP=2, W=1).
module tb_serial_word_collector;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;

    logic       a_start, a_s_bit, a_ready, a_valid, a_busy;
    logic [7:0] a_word;
    logic       b_start, b_s_bit, b_ready, b_valid, b_busy;
    logic [7:0] b_word;
    logic       c_start, c_s_bit, c_ready, c_valid, c_busy;
    logic [0:0] c_word;
`ifdef DESER_PARITY_EN
    logic       a_parity, b_parity, c_parity;
`endif

    int checks = 0;
    int errors = 0;

    serial_word_collector #(.W(8), .SKIP(0)) dut_a (
        .clk(clk), .rst_n(rst_n), .start(a_start), .s_bit(a_s_bit),
        .o_word(a_word), .o_valid(a_valid), .o_ready(a_ready), .busy(a_busy)
`ifdef DESER_PARITY_EN
        , .o_parity(a_parity)
`endif
    );

    serial_word_collector #(.W(8), .SKIP(2)) dut_b (
        .clk(clk), .rst_n(rst_n), .start(b_start), .s_bit(b_s_bit),
        .o_word(b_word), .o_valid(b_valid), .o_ready(b_ready), .busy(b_busy)
`ifdef DESER_PARITY_EN
        , .o_parity(b_parity)
`endif
    );

    serial_word_collector #(.W(1), .SKIP(0)) dut_c (
        .clk(clk), .rst_n(rst_n), .start(c_start), .s_bit(c_s_bit),
        .o_word(c_word), .o_valid(c_valid), .o_ready(c_ready), .busy(c_busy)
`ifdef DESER_PARITY_EN
        , .o_parity(c_parity)
`endif
    );

    task automatic test_reset();
        rst_n = 1'b0;
        a_start = 0; a_s_bit = 0; a_ready = 0;
        b_start = 0; b_s_bit = 0; b_ready = 0;
        c_start = 0; c_s_bit = 0; c_ready = 0;
        #1;
        checks++;
        if (a_word !== 8'h00 || a_valid !== 1'b0 || a_busy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_a: word=%h valid=%b busy=%b expected 00/0/0", a_word, a_valid, a_busy);
        end
        checks++;
        if (b_word !== 8'h00 || b_valid !== 1'b0 || b_busy !== 1'b0 ||
            c_word !== 1'b0 || c_valid !== 1'b0 || c_busy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_bc: b=%h/%b/%b c=%b/%b/%b expected all 0",
                     b_word, b_valid, b_busy, c_word, c_valid, c_busy);
        end
`ifdef DESER_PARITY_EN
        checks++;
        if (a_parity !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_parity: got %b expected 0", a_parity);
        end
`endif
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    // Frame on dut_a with latency check; leaves the unit in HOLD with a_ready low.
    task automatic frame_a(input logic [7:0] data, input string tag);
        a_ready = 1'b0;
        a_start = 1'b1;
        a_s_bit = ~data[7];
        @(negedge clk);
        a_start = 1'b0;
        for (int i = 0; i < 8; i++) begin
            a_s_bit = data[i];
            @(negedge clk);
            checks++;
            if (a_valid !== (i == 7) || a_busy !== 1'b1) begin
                errors++;
                $display("[TB] FAIL %s_latency bit %0d: valid=%b busy=%b expected %b/1",
                         tag, i, a_valid, a_busy, (i == 7));
            end
        end
        checks++;
        if (a_word !== data) begin
            errors++;
            $display("[TB] FAIL %s_word: got %h expected %h", tag, a_word, data);
        end
    endtask

    task automatic test_basic();
        frame_a(8'h4D, "basic");
`ifdef DESER_PARITY_EN
        checks++;
        if (a_parity !== 1'b0) begin
            errors++;
            $display("[TB] FAIL basic_parity: got %b expected 0", a_parity);
        end
`endif
    endtask

    task automatic test_hold();
        for (int k = 0; k < 5; k++) begin
            a_start = (k == 2);
            a_s_bit = k[0];
            @(negedge clk);
            checks++;
            if (a_valid !== 1'b1 || a_word !== 8'h4D || a_busy !== 1'b1) begin
                errors++;
                $display("[TB] FAIL hold_stable cycle %0d: valid=%b word=%h busy=%b expected 1/4d/1",
                         k, a_valid, a_word, a_busy);
            end
        end
        a_ready = 1'b1;
        a_start = 1'b1;
        @(negedge clk);
        a_ready = 1'b0;
        a_start = 1'b0;
        checks++;
        if (a_valid !== 1'b0 || a_busy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL hold_handshake: valid=%b busy=%b expected 0/0", a_valid, a_busy);
        end
        @(negedge clk);
        checks++;
        if (a_busy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL hold_no_requeue: busy=%b expected 0", a_busy);
        end
    endtask

    task automatic test_mid_reset();
        logic [7:0] part = 8'hA5;
        a_start = 1'b1;
        a_s_bit = 1'b0;
        @(negedge clk);
        a_start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            a_s_bit = part[i];
            @(negedge clk);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (a_word !== 8'h00 || a_valid !== 1'b0 || a_busy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL midreset_clear: word=%h valid=%b busy=%b expected 00/0/0",
                     a_word, a_valid, a_busy);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (a_busy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL midreset_idle: busy=%b expected 0", a_busy);
        end
        frame_a(8'h3C, "midreset");
        a_ready = 1'b1;
        @(negedge clk);
        a_ready = 1'b0;
    endtask

    task automatic test_parity();
`ifdef DESER_PARITY_EN
        frame_a(8'h4C, "parity");
        checks++;
        if (a_parity !== 1'b1) begin
            errors++;
            $display("[TB] FAIL parity_4c: got %b expected 1", a_parity);
        end
        a_ready = 1'b1;
        @(negedge clk);
        a_ready = 1'b0;
`endif
    endtask

    task automatic test_skip();
        logic [9:0] stream = {8'h4D, 2'b01};
        b_ready = 1'b0;
        b_start = 1'b1;
        b_s_bit = 1'b1;
        @(negedge clk);
        b_start = 1'b0;
        for (int i = 0; i < 10; i++) begin
            b_s_bit = stream[i];
            @(negedge clk);
            checks++;
            if (b_valid !== (i == 9) || b_busy !== 1'b1) begin
                errors++;
                $display("[TB] FAIL skip_latency bit %0d: valid=%b busy=%b expected %b/1",
                         i, b_valid, b_busy, (i == 9));
            end
        end
        checks++;
        if (b_word !== 8'h4D) begin
            errors++;
            $display("[TB] FAIL skip_word: got %h expected 4d", b_word);
        end
`ifdef DESER_PARITY_EN
        checks++;
        if (b_parity !== 1'b0) begin
            errors++;
            $display("[TB] FAIL skip_parity: got %b expected 0", b_parity);
        end
`endif
        b_ready = 1'b1;
        @(negedge clk);
        b_ready = 1'b0;
        checks++;
        if (b_valid !== 1'b0 || b_busy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL skip_handshake: valid=%b busy=%b expected 0/0", b_valid, b_busy);
        end
    endtask

    task automatic test_back_to_back();
        logic [1:0] bits = 2'b01;
        c_ready = 1'b1;
        for (int f = 0; f < 2; f++) begin
            c_start = 1'b1;
            c_s_bit = ~bits[f];
            @(negedge clk);
            c_start = 1'b0;
            c_s_bit = bits[f];
            checks++;
            if (c_valid !== 1'b0 || c_busy !== 1'b1) begin
                errors++;
                $display("[TB] FAIL w1_collect frame %0d: valid=%b busy=%b expected 0/1", f, c_valid, c_busy);
            end
            @(negedge clk);
            checks++;
            if (c_valid !== 1'b1 || c_word !== bits[f]) begin
                errors++;
                $display("[TB] FAIL w1_word frame %0d: valid=%b word=%b expected 1/%b",
                         f, c_valid, c_word, bits[f]);
            end
            @(negedge clk);
            checks++;
            if (c_valid !== 1'b0 || c_busy !== 1'b0) begin
                errors++;
                $display("[TB] FAIL w1_handshake frame %0d: valid=%b busy=%b expected 0/0", f, c_valid, c_busy);
            end
        end
        c_ready = 1'b0;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_hold();
        test_mid_reset();
        test_parity();
        test_skip();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
